// File: rtl/cmp_nibble_seq_if.sv
// Request/response bundle for the nibble compare sequencer.
// master = requester/consumer side, slave = sequencer side.
interface cmp_nibble_seq_if #(
   parameter int WIDTH = 16
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = $clog2(NSLICE) + 1;

   logic             req_valid;
   logic             req_ready;
   logic             signed_mode;
   logic [WIDTH-1:0] inp1;
   logic [WIDTH-1:0] inp2;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             a_less;
   logic             a_greater;
   logic             equal;
   logic [CW-1:0]    slice_cnt;

   modport master (
      output req_valid, signed_mode, inp1, inp2, rsp_ready,
      input  req_ready, rsp_valid, a_less, a_greater, equal,
      input  slice_cnt
   );

   modport slave (
      input  req_valid, signed_mode, inp1, inp2, rsp_ready,
      output req_ready, rsp_valid, a_less, a_greater, equal,
      output slice_cnt
   );
endinterface

// File: rtl/cmp_nibble_seq.sv
// Multi-cycle magnitude compare, one 4-bit slice per cycle,
// MSB slice first, early exit on the first unequal slice.
module cmp_nibble_seq #(
   parameter int WIDTH = 16
) (
   input logic              clk,
   input logic              rst_n,
   cmp_nibble_seq_if.slave  bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CW     = $clog2(NSLICE) + 1;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] a_d, b_d;
   logic [WIDTH-1:0] msb_flip;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    slc_q;
   logic             lt_q, gt_q, eq_q;
   logic [3:0]       sa, sb;
   logic             s_lt, s_gt;

   // Offset-binary capture turns a signed compare into an unsigned one
   always_comb begin
      msb_flip = '0;
      msb_flip[WIDTH-1] = bus.signed_mode;
      a_d   = bus.inp1 ^ msb_flip;
      b_d   = bus.inp2 ^ msb_flip;
      idx_d = idx_q - IW'(1);
      cnt_d = cnt_q + CW'(1);
   end

   // Select the current slice and compare it
   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IW'(i)) begin
            sa = a_q[4*i +: 4];
            sb = b_q[4*i +: 4];
         end
      end
      s_lt = (sa < sb);
      s_gt = (sa > sb);
   end

   // Sequencer FSM with registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         slc_q   <= '0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  idx_q   <= IW'(NSLICE - 1);
                  cnt_q   <= CW'(1);
                  state_q <= CMP;
               end
            end
            CMP: begin
               if (s_lt || s_gt) begin
                  lt_q    <= s_lt;
                  gt_q    <= s_gt;
                  eq_q    <= 1'b0;
                  slc_q   <= cnt_q;
                  state_q <= RESP;
               end else if (idx_q == '0) begin
                  lt_q    <= 1'b0;
                  gt_q    <= 1'b0;
                  eq_q    <= 1'b1;
                  slc_q   <= CW'(NSLICE);
                  state_q <= RESP;
               end else begin
                  idx_q <= idx_d;
                  cnt_q <= cnt_d;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.a_less    = lt_q;
   assign bus.a_greater = gt_q;
   assign bus.equal     = eq_q;
   assign bus.slice_cnt = slc_q;
endmodule
